// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle core's bus.
// Serves word RAM, a console TX byte FIFO with a valid/ready drain port,
// a halt/exit (TOHOST) register and, when MEM_RESPONDER_CYCLE_COUNTER_EN
// is defined, a free-running cycle counter at 0x1000_0008.
// Reads are combinational from address; writes commit on the rising edge.
module mem_responder #(
   parameter int MEM_WORDS  = 4096,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] address,
   input  logic [31:0] data_out,
   input  logic        we,
   output logic [31:0] data_in,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        halt,
   output logic [31:0] exit_code,
   output logic        bus_err
);

   localparam int MAW = $clog2(MEM_WORDS);
   localparam int FAW = $clog2(FIFO_DEPTH);

   localparam logic [31:0] CONSOLE_ADDR = 32'h1000_0000;
   localparam logic [31:0] TOHOST_ADDR  = 32'h1000_0004;
   localparam logic [31:0] CYCLE_ADDR   = 32'h1000_0008;
   localparam logic [FAW:0] PTR_ONE     = {{FAW{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      SEL_RAM,
      SEL_CONSOLE,
      SEL_TOHOST,
      SEL_CYCLE,
      SEL_NONE
   } sel_e;

   sel_e        sel;

   logic [31:0] mem_q  [MEM_WORDS];
   logic [7:0]  fifo_q [FIFO_DEPTH];

   logic [FAW:0] wr_ptr_q, wr_ptr_d;
   logic [FAW:0] rd_ptr_q, rd_ptr_d;
   logic         halt_q, halt_d;
   logic [31:0]  exit_code_q, exit_code_d;
   logic         bus_err_q, bus_err_d;

   logic fifo_empty;
   logic fifo_full;
   logic wr_en;
   logic push_req;
   logic push;
   logic pop;
   logic overflow;

   // Address decode: pick the target region for the current bus address.
   // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      sel = SEL_NONE;
      if (address[31:MAW+2] == '0) begin
         sel = SEL_RAM;
      end else if (address == CONSOLE_ADDR) begin
         sel = SEL_CONSOLE;
      end else if (address == TOHOST_ADDR) begin
         sel = SEL_TOHOST;
`ifdef MEM_RESPONDER_CYCLE_COUNTER_EN
      end else if (address == CYCLE_ADDR) begin
         sel = SEL_CYCLE;
`endif
      end
   end

   // Once halted, the core can no longer change any state through writes.
   assign wr_en      = we && !halt_q;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[FAW-1:0] == rd_ptr_q[FAW-1:0]) &&
                       (wr_ptr_q[FAW] != rd_ptr_q[FAW]);

   assign pop        = !fifo_empty && tx_ready;
   assign push_req   = wr_en && (sel == SEL_CONSOLE);
   // A pop in the same cycle frees the head slot, so a full FIFO can still take the byte.
   assign push       = push_req && (!fifo_full || pop);
   assign overflow   = push_req && fifo_full && !pop;

   // Next-state computation for pointers, halt/exit and the sticky error flag.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      halt_d      = halt_q;
      exit_code_d = exit_code_q;
      bus_err_d   = bus_err_q;
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (wr_en && (sel == SEL_TOHOST)) begin
         halt_d      = 1'b1;
         exit_code_d = data_out;
      end
      if (overflow || (wr_en && (sel == SEL_NONE))) begin
         bus_err_d = 1'b1;
      end
   end

   // Control state registers; reset discards queued bytes and any coincident MMIO write.
   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         halt_q      <= 1'b0;
         exit_code_q <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         halt_q      <= halt_d;
         exit_code_q <= exit_code_d;
         bus_err_q   <= bus_err_d;
      end
   end

   // RAM write port; a RAM write coincident with reset still lands.
   // NOTE: storage arrays have no reset so they map onto plain RAM; their contents stay valid across a reset.
   always_ff @(posedge clk) begin
      if (wr_en && (sel == SEL_RAM)) begin
         mem_q[address[MAW+1:2]] <= data_out;
      end
   end

   // Console FIFO storage; the byte goes into the slot at the write pointer.
   always_ff @(posedge clk) begin
      if (push && resetn) begin
         fifo_q[wr_ptr_q[FAW-1:0]] <= data_out[7:0];
      end
   end

`ifdef MEM_RESPONDER_CYCLE_COUNTER_EN
   logic [31:0] cycle_q, cycle_d;

   assign cycle_d = halt_q ? cycle_q : cycle_q + 32'd1;

   // Cycle counter: runs until halt, wraps naturally at 32 bits.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cycle_q <= '0;
      end else begin
         cycle_q <= cycle_d;
      end
   end
`endif

   // Combinational read mux driven by the decoded region.
   always_comb begin
      data_in = '0;
      case (sel)
         SEL_RAM:     data_in = mem_q[address[MAW+1:2]];
         SEL_CONSOLE: data_in = {30'b0, fifo_full, fifo_empty};
         SEL_TOHOST:  data_in = exit_code_q;
`ifdef MEM_RESPONDER_CYCLE_COUNTER_EN
         SEL_CYCLE:   data_in = cycle_q;
`endif
         default:     data_in = '0;
      endcase
   end

   // Drain port comes straight from registers and the FIFO array, never from tx_ready.
   assign tx_data   = fifo_q[rd_ptr_q[FAW-1:0]];
   assign tx_valid  = !fifo_empty;
   assign halt      = halt_q;
   assign exit_code = exit_code_q;
   assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder. A transaction-level
// model (byte queue, sparse RAM, flags) is updated at each rising edge from
// the bus inputs; one compare process checks every DUT output against it at
// each falling edge. Directed steps add literal expectations that pin the model.
// Honours MEM_RESPONDER_CYCLE_COUNTER_EN the same way as the design.
module tb_mem_responder;

   localparam int MEM_WORDS  = 4096;
   localparam int FIFO_DEPTH = 4;

   localparam logic [31:0] CONSOLE = 32'h1000_0000;
   localparam logic [31:0] TOHOST  = 32'h1000_0004;
   localparam logic [31:0] CYCLE   = 32'h1000_0008;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] address;
   logic [31:0] data_out;
   logic        we;
   logic [31:0] data_in;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        halt;
   logic [31:0] exit_code;
   logic        bus_err;

   mem_responder #(
      .MEM_WORDS  (MEM_WORDS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .address   (address),
      .data_out  (data_out),
      .we        (we),
      .data_in   (data_in),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .halt      (halt),
      .exit_code (exit_code),
      .bus_err   (bus_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0]  q_m [$];
   logic [31:0] ram_m [int unsigned];
   bit          halt_m;
   logic [31:0] exit_m;
   bit          err_m;
   logic [31:0] cycle_m;
   int          sz_m;
   bit          pop_m;
   bit          wr_m;

   function automatic bit is_ram(input logic [31:0] a);
      return a < 32'(4 * MEM_WORDS);
   endfunction

   always @(posedge clk) begin
      sz_m  = q_m.size();
      wr_m  = we && !halt_m;
      // RAM writes are honoured even in a reset cycle.
      if (wr_m && is_ram(address)) ram_m[address >> 2] = data_out;
      if (!resetn) begin
         q_m.delete();
         halt_m  = 1'b0;
         exit_m  = '0;
         err_m   = 1'b0;
         cycle_m = '0;
      end else begin
         pop_m = (sz_m > 0) && tx_ready;
         if (!halt_m) cycle_m = cycle_m + 32'd1;
         if (pop_m) void'(q_m.pop_front());
         if (wr_m) begin
            if (address == CONSOLE) begin
               if (sz_m < FIFO_DEPTH || pop_m) q_m.push_back(data_out[7:0]);
               else err_m = 1'b1;
            end else if (address == TOHOST) begin
               halt_m = 1'b1;
               exit_m = data_out;
            end else if (address == CYCLE) begin
`ifndef MEM_RESPONDER_CYCLE_COUNTER_EN
               err_m = 1'b1;
`endif
            end else if (!is_ram(address)) begin
               err_m = 1'b1;
            end
         end
      end
   end

   function automatic bit exp_read(input logic [31:0] a, output logic [31:0] v);
      v = '0;
      if (is_ram(a)) begin
         if (!ram_m.exists(a >> 2)) return 1'b0;
         v = ram_m[a >> 2];
      end else if (a == CONSOLE) begin
         v = {30'b0, q_m.size() == FIFO_DEPTH, q_m.size() == 0};
      end else if (a == TOHOST) begin
         v = exit_m;
`ifdef MEM_RESPONDER_CYCLE_COUNTER_EN
      end else if (a == CYCLE) begin
         v = cycle_m;
`endif
      end
      return 1'b1;
   endfunction

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      logic [31:0] v;
      if (chk_en) begin
         check("m_tx_valid", {31'b0, tx_valid}, {31'b0, q_m.size() != 0});
         if (q_m.size() != 0) check("m_tx_data", {24'b0, tx_data}, {24'b0, q_m[0]});
         check("m_halt", {31'b0, halt}, {31'b0, halt_m});
         check("m_exit_code", exit_code, exit_m);
         check("m_bus_err", {31'b0, bus_err}, {31'b0, err_m});
         if (exp_read(address, v)) check("m_data_in", data_in, v);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      address  = a;
      data_out = d;
      we       = 1'b1;
      tick();
      we       = 1'b0;
   endtask

   task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
      address = a;
      @(negedge clk);
      check(name, data_in, exp);
      tick();
   endtask

   task automatic expect_head(input string name, input logic [7:0] b);
      @(negedge clk);
      check({name, "_valid"}, {31'b0, tx_valid}, 32'd1);
      check(name, {24'b0, tx_data}, {24'b0, b});
   endtask

   task automatic expect_empty(input string name);
      @(negedge clk);
      check(name, {31'b0, tx_valid}, 32'd0);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
   endtask

   logic [31:0] c0, c1;

   initial begin
      resetn   = 1'b0;
      address  = '0;
      data_out = '0;
      we       = 1'b0;
      tx_ready = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
      chk_en = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
      check("rst_halt", {31'b0, halt}, 32'd0);
      check("rst_exit_code", exit_code, 32'd0);
      check("rst_bus_err", {31'b0, bus_err}, 32'd0);
      tick();
      rd_check("rst_console_status", CONSOLE, 32'd1);

      // RAM write/read
      wr(32'h14, 32'h1111_1111);
      wr(32'h00, 32'h0000_1234);
      wr(32'h10, 32'hDEAD_BEEF);
      rd_check("ram_rd_10", 32'h10, 32'hDEAD_BEEF);
      rd_check("ram_rd_13", 32'h13, 32'hDEAD_BEEF);
      rd_check("ram_rd_14", 32'h14, 32'h1111_1111);

      // Console fill and overflow with tx_ready low
      for (int i = 0; i < 4; i++) wr(CONSOLE, 32'h41 + 32'(i));
      rd_check("console_full_status", CONSOLE, 32'd2);
      check("no_err_before_overflow", {31'b0, bus_err}, 32'd0);
      wr(CONSOLE, 32'h45);
      @(negedge clk);
      check("overflow_bus_err", {31'b0, bus_err}, 32'd1);
      tick();
      tx_ready = 1'b1;
      expect_head("drain1_0", 8'h41);
      expect_head("drain1_1", 8'h42);
      expect_head("drain1_2", 8'h43);
      expect_head("drain1_3", 8'h44);
      expect_empty("drain1_empty");
      tick();
      tx_ready = 1'b0;

      // Full with simultaneous push and pop
      do_reset();
      for (int i = 1; i <= 4; i++) wr(CONSOLE, 32'(i));
      address  = CONSOLE;
      data_out = 32'h05;
      we       = 1'b1;
      tx_ready = 1'b1;
      @(negedge clk);
      check("pp_status_pre_edge", data_in, 32'd2);
      check("pp_head_pre", {24'b0, tx_data}, 32'h01);
      tick();
      we = 1'b0;
      expect_head("drain2_0", 8'h02);
      check("pp_bus_err", {31'b0, bus_err}, 32'd0);
      expect_head("drain2_1", 8'h03);
      expect_head("drain2_2", 8'h04);
      expect_head("drain2_3", 8'h05);
      expect_empty("drain2_empty");
      tick();
      tx_ready = 1'b0;

      // Unmapped access, then reset with bytes queued
      wr(32'h2000_0000, 32'h1);
      address = 32'h2000_0000;
      @(negedge clk);
      check("unmapped_rd", data_in, 32'd0);
      check("unmapped_bus_err", {31'b0, bus_err}, 32'd1);
      tick();
      wr(CONSOLE, 32'h71);
      wr(CONSOLE, 32'h72);
      address  = 32'h20;
      data_out = 32'hA5A5_A5A5;
      we       = 1'b1;
      do_reset();
      we = 1'b0;
      @(negedge clk);
      check("post_rst_tx_valid", {31'b0, tx_valid}, 32'd0);
      check("post_rst_bus_err", {31'b0, bus_err}, 32'd0);
      check("post_rst_halt", {31'b0, halt}, 32'd0);
      tick();
      rd_check("ram_retained", 32'h10, 32'hDEAD_BEEF);
      rd_check("ram_wr_in_reset", 32'h20, 32'hA5A5_A5A5);

      // Cycle counter
      address = CYCLE;
      @(negedge clk);
      c0 = data_in;
      repeat (10) @(negedge clk);
      c1 = data_in;
`ifdef MEM_RESPONDER_CYCLE_COUNTER_EN
      check("cycle_delta", c1 - c0, 32'd10);
`else
      check("cycle_rd_zero", c1, 32'd0);
`endif
      tick();
      wr(CYCLE, 32'h1234);
      @(negedge clk);
`ifdef MEM_RESPONDER_CYCLE_COUNTER_EN
      check("cycle_wr_no_err", {31'b0, bus_err}, 32'd0);
`else
      check("cycle_wr_err", {31'b0, bus_err}, 32'd1);
`endif
      tick();

      // Halt freeze with console bytes pending
      wr(CONSOLE, 32'h61);
      wr(CONSOLE, 32'h62);
      wr(TOHOST, 32'd7);
      @(negedge clk);
      check("halt_set", {31'b0, halt}, 32'd1);
      check("exit_code_7", exit_code, 32'd7);
      tick();
      wr(TOHOST, 32'd9);
      wr(32'h0, 32'h55);
      wr(CONSOLE, 32'h63);
      @(negedge clk);
      check("exit_code_kept", exit_code, 32'd7);
      tick();
      rd_check("ram_frozen", 32'h0, 32'h0000_1234);
      rd_check("tohost_rd", TOHOST, 32'd7);
`ifdef MEM_RESPONDER_CYCLE_COUNTER_EN
      address = CYCLE;
      @(negedge clk);
      c0 = data_in;
      repeat (5) @(negedge clk);
      c1 = data_in;
      check("cycle_frozen", c1 - c0, 32'd0);
      tick();
`endif
      tx_ready = 1'b1;
      expect_head("drain3_0", 8'h61);
      expect_head("drain3_1", 8'h62);
      expect_empty("drain3_empty");
      tick();
      tx_ready = 1'b0;
      tick();

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
